input_vc_buffer: RTL and testbench
==================================

# input_vc_buffer

Per-port input buffer that sits directly upstream of `route_comp`. It accepts flits from the incoming link, stores them in two virtual-channel FIFOs selected by the head flit's VC-class bit, and presents one flit at a time to the route-computation stage. Packets are never interleaved on the output. Freed slots are returned upstream as per-VC credits.

## Interface
- `FLIT_SIZE`, default from para.sv: flit width.
- `HEADER_LEN`, default from para.sv: width of the type field at `[FLIT_SIZE-1 -: HEADER_LEN]`.
- `VC_CLASS_POS`, default from para.sv: bit index of the VC-class bit in HEAD/SINGLE flits.
- `DEPTH`, default 4: entries per VC FIFO. Must be a power of 2, ≥2.
- `PORT_DIR`, default 0: constant driven on `dir_in`, naming this input port.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-low reset.
- `flit_in` in FLIT_SIZE: flit from the link.
- `flit_valid_in` in 1: `flit_in` is valid this cycle.
- `stall` in 1: downstream (`route_comp`) cannot accept a flit.
- `flit_out` in the output direction, FLIT_SIZE: flit presented to `route_comp` (`flit_before_RC`).
- `flit_valid_out` out 1: `flit_out` is valid.
- `dir_in` out 3: equals `PORT_DIR`.
- `credit_out` out 2: per-VC one-cycle credit pulse to the upstream router.
- `overflow_err` out 1: sticky; set when a flit is written to a full VC.

## Operation
- Write VC selection:
  - A HEAD or SINGLE flit is written to the VC given by `flit_in[VC_CLASS_POS]`, and that VC is latched into `wr_vc`.
  - BODY and TAIL flits are written to `wr_vc`.
- Write acceptance: a write to a VC whose count equals `DEPTH` *before* the edge is dropped and sets `overflow_err`. This holds even if that VC is dequeued in the same cycle.
- FIFOs: show-ahead. The head entry is visible combinationally. There is no write-to-read bypass.
- Read arbiter FSM, states IDLE, LOCK0, LOCK1:
  - **IDLE:**
    - Candidate VCs are those that are non-empty and whose head entry has type HEAD or SINGLE.
    - If both VCs are candidates, select the VC that is not `last_vc` (round-robin).
    - When a HEAD is dequeued, go to LOCKv and set `last_vc = v`.
    - When a SINGLE is dequeued, set `last_vc = v` and stay in IDLE.
    - A non-empty VC whose head entry is BODY or TAIL is never selected in IDLE.
  - **LOCKv:**
    - Only VC v is served.
    - `flit_valid_out` = VC v non-empty.
    - When a TAIL is dequeued, return to IDLE.
- Output: `flit_out` is the head entry of the selected VC. When nothing is selected, `flit_out` holds the VC0 head entry and `flit_valid_out` is 0.
- Dequeue happens on an edge where `flit_valid_out && !stall`.
- Credits: `credit_out[v]` is registered and pulses high for exactly one cycle, in the cycle after VC v is dequeued. The upstream router starts with `DEPTH` credits per VC.
- Arithmetic:
  - Pointers are `$clog2(DEPTH)` bits and wrap naturally.
  - Counts are `$clog2(DEPTH)+1` bits.
  - A simultaneous enqueue and dequeue on one VC leaves the count unchanged.

## Timing
- Reset (`rst` low, asynchronous) clears:
  - all pointers and counts to 0;
  - the state to IDLE;
  - `wr_vc`, `last_vc`, `credit_out`, `overflow_err` to 0.
- Consequently, during reset `flit_valid_out` = 0. FIFO data is not reset.
- Reset asserted mid-packet discards all stored flits. No credits are emitted for discarded flits.
- Latency: a flit written at edge N has `flit_valid_out` high in cycle N+1, provided its VC is selectable.
- Credit: dequeue at edge N → `credit_out[v]` high from N to N+1.
- Throughput: one flit per cycle in, and one flit per cycle out.
- `stall` high holds `flit_out`, `flit_valid_out` and the state unchanged.

## Structure
- Flit type encodings (HEAD_FLIT, BODY_FLIT, TAIL_FLIT, SINGLE_FLIT), `FLIT_SIZE`, `HEADER_LEN` and `VC_CLASS_POS` come from the shared para.sv package.
- The arbiter state enum is added to para.sv.
- Natural sub-module: `vc_fifo`, a show-ahead FIFO with count, instantiated twice.

## Test plan
- **Single flit:** reset, then write one SINGLE flit with VC bit 1.
  - `flit_valid_out` is high in the next cycle.
  - With `stall` = 0, after dequeue `credit_out` = 2'b10 for exactly one cycle.
- **Interleaved inputs, no interleaved outputs:** write VC0 packet H,B,T and VC1 packet H,T on alternating cycles.
  - Output order is VC0 H,B,T followed by VC1 H,T.
  - The output never interleaves the two packets.
- **Stall:** hold `stall` = 1 for 5 cycles with a packet waiting.
  - `flit_out` is stable and no credits pulse.
  - Release `stall`: one flit is dequeued per cycle.
- **Overflow:** with `DEPTH` = 4 and `stall` = 1, write 5 flits to VC0.
  - `overflow_err` = 1 and the VC0 count is 4.
  - Draining produces exactly 4 flits and 4 credit pulses.
- **Round-robin:** SINGLE flits waiting on both VCs, `last_vc` = 0.
  - VC1 is issued first, then VC0.
- **Mid-packet reset:** assert `rst` low after a HEAD is dequeued.
  - Outputs are 0 immediately.
  - After release, the state is IDLE and a new packet on VC1 is accepted normally.

Source files
------------

// File: rtl/input_vc_buffer_pkg.sv
// Shared router constants for the input VC buffer: flit layout, flit type
// encodings and the read-arbiter state encoding.
package input_vc_buffer_pkg;

    localparam int FLIT_SIZE    = 16;
    localparam int HEADER_LEN   = 2;
    localparam int VC_CLASS_POS = 13;

    localparam logic [HEADER_LEN-1:0] HEAD_FLIT   = 2'b00;
    localparam logic [HEADER_LEN-1:0] BODY_FLIT   = 2'b01;
    localparam logic [HEADER_LEN-1:0] TAIL_FLIT   = 2'b10;
    localparam logic [HEADER_LEN-1:0] SINGLE_FLIT = 2'b11;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_LOCK0 = 2'd1,
        ARB_LOCK1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/input_vc_buffer_vc_fifo.sv
// Show-ahead FIFO for one virtual channel. The head entry is always visible
// on head_data; writes to a full FIFO are silently dropped (the caller
// flags the overflow). No write-to-read bypass.
module vc_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // Fullness/emptiness are judged on the count before the edge, so a
    // write to a full FIFO is dropped even if it is also read this cycle.
    assign do_wr     = wr_en && (count != CW'(DEPTH));
    assign do_rd     = rd_en && (count != '0);
    assign head_data = mem[rd_ptr];

    // Storage array; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally; simultaneous push and pop keep the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PW'(1);
            if (do_rd) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_wr) - CW'(do_rd);
        end
    end

endmodule

// File: rtl/input_vc_buffer.sv
// Per-port input buffer: steers link flits into two VC FIFOs by the head
// flit's VC-class bit, serves whole packets (never interleaved) to route
// computation, and returns a one-cycle credit per dequeued flit.
// Handshake: a flit leaves on every rising edge where flit_valid_out is
// high and stall is low; flit_out/flit_valid_out stay put while stalled.
module input_vc_buffer #(
    parameter int FLIT_SIZE    = input_vc_buffer_pkg::FLIT_SIZE,
    parameter int HEADER_LEN   = input_vc_buffer_pkg::HEADER_LEN,
    parameter int VC_CLASS_POS = input_vc_buffer_pkg::VC_CLASS_POS,
    parameter int DEPTH        = 4,
    parameter int PORT_DIR     = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FLIT_SIZE-1:0] flit_in,
    input  logic                 flit_valid_in,
    input  logic                 stall,
    output logic [FLIT_SIZE-1:0] flit_out,
    output logic                 flit_valid_out,
    output logic [2:0]           dir_in,
    output logic [1:0]           credit_out,
    output logic                 overflow_err
);

    import input_vc_buffer_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [HEADER_LEN-1:0] T_HEAD   = HEADER_LEN'(HEAD_FLIT);
    localparam logic [HEADER_LEN-1:0] T_TAIL   = HEADER_LEN'(TAIL_FLIT);
    localparam logic [HEADER_LEN-1:0] T_SINGLE = HEADER_LEN'(SINGLE_FLIT);

    arb_state_t            state;
    logic                  wr_vc;
    logic                  last_vc;
    logic [HEADER_LEN-1:0] in_type;
    logic                  in_is_head;
    logic                  wr_sel;
    logic [1:0]            wr_req;
    logic [1:0]            rd_en;
    logic [1:0]            empty;
    logic [1:0]            full;
    logic [1:0]            cand;
    logic [FLIT_SIZE-1:0]  head_data [2];
    logic [CW-1:0]         count [2];
    logic                  sel_vc;
    logic                  sel_valid;
    logic                  deq;
    logic [HEADER_LEN-1:0] out_type;

    assign dir_in = 3'(PORT_DIR);

    assign in_type    = flit_in[FLIT_SIZE-1 -: HEADER_LEN];
    assign in_is_head = (in_type == T_HEAD) || (in_type == T_SINGLE);
    assign wr_sel     = in_is_head ? flit_in[VC_CLASS_POS] : wr_vc;
    assign wr_req[0]  = flit_valid_in && !wr_sel;
    assign wr_req[1]  = flit_valid_in &&  wr_sel;

    for (genvar v = 0; v < 2; v++) begin : g_vc
        vc_fifo #(.WIDTH(FLIT_SIZE), .DEPTH(DEPTH)) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .wr_en     (wr_req[v]),
            .wr_data   (flit_in),
            .rd_en     (rd_en[v]),
            .head_data (head_data[v]),
            .count     (count[v])
        );
        assign empty[v] = (count[v] == '0);
        assign full[v]  = (count[v] == CW'(DEPTH));
        // Only a packet start may win arbitration while idle.
        assign cand[v]  = !empty[v] &&
                          ((head_data[v][FLIT_SIZE-1 -: HEADER_LEN] == T_HEAD) ||
                           (head_data[v][FLIT_SIZE-1 -: HEADER_LEN] == T_SINGLE));
    end

    // Read selection: round-robin among packet starts when idle, locked VC otherwise.
    always_comb begin
        sel_vc    = 1'b0;
        sel_valid = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (cand == 2'b11) begin
                    sel_vc    = ~last_vc;
                    sel_valid = 1'b1;
                end else if (cand[1]) begin
                    sel_vc    = 1'b1;
                    sel_valid = 1'b1;
                end else if (cand[0]) begin
                    sel_vc    = 1'b0;
                    sel_valid = 1'b1;
                end
            end
            ARB_LOCK0: begin
                sel_vc    = 1'b0;
                sel_valid = !empty[0];
            end
            ARB_LOCK1: begin
                sel_vc    = 1'b1;
                sel_valid = !empty[1];
            end
            default: begin
                sel_vc    = 1'b0;
                sel_valid = 1'b0;
            end
        endcase
    end

    assign flit_out       = sel_valid ? head_data[sel_vc] : head_data[0];
    assign flit_valid_out = sel_valid;
    assign out_type       = flit_out[FLIT_SIZE-1 -: HEADER_LEN];
    assign deq            = sel_valid && !stall;
    assign rd_en[0]       = deq && !sel_vc;
    assign rd_en[1]       = deq &&  sel_vc;

    // Arbiter FSM: lock onto a VC after its HEAD leaves, release after TAIL.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ARB_IDLE;
            last_vc <= 1'b0;
        end else if (deq) begin
            case (state)
                ARB_IDLE: begin
                    if (out_type == T_HEAD) begin
                        state   <= sel_vc ? ARB_LOCK1 : ARB_LOCK0;
                        last_vc <= sel_vc;
                    end else if (out_type == T_SINGLE) begin
                        last_vc <= sel_vc;
                    end
                end
                ARB_LOCK0, ARB_LOCK1: begin
                    if (out_type == T_TAIL) state <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Write-side VC tracking, credit pulses and sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_vc        <= 1'b0;
            credit_out   <= 2'b00;
            overflow_err <= 1'b0;
        end else begin
            if (flit_valid_in && in_is_head) wr_vc <= flit_in[VC_CLASS_POS];
            credit_out <= rd_en;
            if (|(wr_req & full)) overflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_input_vc_buffer.sv
// Directed bench for input_vc_buffer: single flit, packet ordering, stall,
// overflow, round-robin and mid-packet reset.
module tb_input_vc_buffer;

    localparam int FS = 16;

    logic          clk;
    logic          rst;
    logic [FS-1:0] flit_in;
    logic          flit_valid_in;
    logic          stall;
    logic [FS-1:0] flit_out;
    logic          flit_valid_out;
    logic [2:0]    dir_in;
    logic [1:0]    credit_out;
    logic          overflow_err;

    int n_vec = 0;
    int n_err = 0;
    int crd0_cnt = 0;

    input_vc_buffer #(.DEPTH(4), .PORT_DIR(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .flit_in        (flit_in),
        .flit_valid_in  (flit_valid_in),
        .stall          (stall),
        .flit_out       (flit_out),
        .flit_valid_out (flit_valid_out),
        .dir_in         (dir_in),
        .credit_out     (credit_out),
        .overflow_err   (overflow_err)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1);
    end

    // Flit layout: [15:14] type, [13] VC class, [12:0] payload.
    function automatic logic [FS-1:0] mk(input logic [1:0] t, input logic vc,
                                         input logic [12:0] pl);
        return {t, vc, pl};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", tag, obs, exp);
        end
    endtask

    // Drive one flit for one rising edge; returns 1ns after that edge.
    task automatic drive(input logic [FS-1:0] f);
        flit_in       = f;
        flit_valid_in = 1'b1;
        @(posedge clk);
        #1;
        flit_valid_in = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    // Sample outputs at the falling edge and compare.
    task automatic expect_out(input string tag, input logic v,
                              input logic [FS-1:0] f, input logic [1:0] c);
        @(negedge clk);
        check({tag, "_valid"}, 32'(flit_valid_out), 32'(v));
        if (v) check({tag, "_flit"}, 32'(flit_out), 32'(f));
        check({tag, "_credit"}, 32'(credit_out), 32'(c));
        if (credit_out[0]) crd0_cnt++;
    endtask

    localparam logic [1:0] H = 2'b00, B = 2'b01, T = 2'b10, S = 2'b11;

    initial begin
        rst           = 1'b0;
        flit_in       = '0;
        flit_valid_in = 1'b0;
        stall         = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state.
        @(negedge clk);
        check("rst_valid", 32'(flit_valid_out), 32'd0);
        check("rst_credit", 32'(credit_out), 32'd0);
        check("rst_ovf", 32'(overflow_err), 32'd0);
        check("dir_in", 32'(dir_in), 32'd3);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Single flit on VC1.
        drive(mk(S, 1'b1, 13'h011));
        expect_out("single0", 1'b1, mk(S, 1'b1, 13'h011), 2'b00);
        expect_out("single1", 1'b0, '0, 2'b10);
        expect_out("single2", 1'b0, '0, 2'b00);

        // Packets written on alternating cycles; output must not interleave.
        // last_vc is 1 here, so VC0 wins the first tie.
        stall = 1'b1;
        drive(mk(H, 1'b0, 13'h100)); idle_cycle();
        drive(mk(B, 1'b0, 13'h101)); idle_cycle();
        drive(mk(T, 1'b0, 13'h102)); idle_cycle();
        drive(mk(H, 1'b1, 13'h200)); idle_cycle();
        drive(mk(T, 1'b1, 13'h201));
        stall = 1'b0;
        expect_out("pkt_h0", 1'b1, mk(H, 1'b0, 13'h100), 2'b00);
        expect_out("pkt_b0", 1'b1, mk(B, 1'b0, 13'h101), 2'b01);
        expect_out("pkt_t0", 1'b1, mk(T, 1'b0, 13'h102), 2'b01);
        expect_out("pkt_h1", 1'b1, mk(H, 1'b1, 13'h200), 2'b01);
        expect_out("pkt_t1", 1'b1, mk(T, 1'b1, 13'h201), 2'b10);
        expect_out("pkt_end0", 1'b0, '0, 2'b10);
        expect_out("pkt_end1", 1'b0, '0, 2'b00);

        // Stall holds the waiting head with no credits.
        stall = 1'b1;
        drive(mk(H, 1'b0, 13'h300));
        drive(mk(T, 1'b0, 13'h301));
        for (int i = 0; i < 5; i++) begin
            expect_out($sformatf("stall%0d", i), 1'b1, mk(H, 1'b0, 13'h300), 2'b00);
        end
        stall = 1'b0;
        expect_out("unstall_t", 1'b1, mk(T, 1'b0, 13'h301), 2'b01);
        expect_out("unstall_e0", 1'b0, '0, 2'b01);
        expect_out("unstall_e1", 1'b0, '0, 2'b00);

        // Overflow: fifth write to a full VC0 is dropped and flagged.
        stall = 1'b1;
        drive(mk(H, 1'b0, 13'h400));
        drive(mk(B, 1'b0, 13'h401));
        drive(mk(B, 1'b0, 13'h402));
        drive(mk(T, 1'b0, 13'h403));
        @(negedge clk);
        check("ovf_before", 32'(overflow_err), 32'd0);
        drive(mk(B, 1'b0, 13'h404));
        @(negedge clk);
        check("ovf_after", 32'(overflow_err), 32'd1);
        check("ovf_head", 32'(flit_out), 32'(mk(H, 1'b0, 13'h400)));
        crd0_cnt = 0;
        stall = 1'b0;
        expect_out("drain_b0", 1'b1, mk(B, 1'b0, 13'h401), 2'b01);
        expect_out("drain_b1", 1'b1, mk(B, 1'b0, 13'h402), 2'b01);
        expect_out("drain_t", 1'b1, mk(T, 1'b0, 13'h403), 2'b01);
        expect_out("drain_e0", 1'b0, '0, 2'b01);
        expect_out("drain_e1", 1'b0, '0, 2'b00);
        check("drain_credits", 32'(crd0_cnt), 32'd4);
        check("ovf_sticky", 32'(overflow_err), 32'd1);

        // Round-robin: last_vc is 0, so VC1 goes first.
        stall = 1'b1;
        drive(mk(S, 1'b0, 13'h500));
        drive(mk(S, 1'b1, 13'h501));
        stall = 1'b0;
        expect_out("rr_vc1", 1'b1, mk(S, 1'b1, 13'h501), 2'b00);
        expect_out("rr_vc0", 1'b1, mk(S, 1'b0, 13'h500), 2'b10);
        expect_out("rr_e0", 1'b0, '0, 2'b01);
        expect_out("rr_e1", 1'b0, '0, 2'b00);

        // Mid-packet reset after the HEAD leaves VC1.
        stall = 1'b1;
        drive(mk(H, 1'b1, 13'h600));
        drive(mk(B, 1'b1, 13'h601));
        stall = 1'b0;
        expect_out("mid_h", 1'b1, mk(H, 1'b1, 13'h600), 2'b00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(flit_valid_out), 32'd0);
        check("mid_rst_credit", 32'(credit_out), 32'd0);
        check("mid_rst_ovf", 32'(overflow_err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        // After reset last_vc is 0 and the state is idle: VC1 packet first,
        // and the discarded BODY must not reappear.
        stall = 1'b1;
        drive(mk(S, 1'b0, 13'h700));
        drive(mk(H, 1'b1, 13'h710));
        drive(mk(T, 1'b1, 13'h711));
        stall = 1'b0;
        expect_out("post_h1", 1'b1, mk(H, 1'b1, 13'h710), 2'b00);
        expect_out("post_t1", 1'b1, mk(T, 1'b1, 13'h711), 2'b10);
        expect_out("post_s0", 1'b1, mk(S, 1'b0, 13'h700), 2'b10);
        expect_out("post_e0", 1'b0, '0, 2'b01);
        expect_out("post_e1", 1'b0, '0, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
